fetch_unit: RTL and testbench

//  PC generator and fetch sequencer for the CPU core. Drives the address of the synchronous instruction

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// PC generator and fetch sequencer: drives the synchronous instruction memory address and pairs
// each returned word with its PC and a valid flag for decode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_BOOT   | out of reset, RESET_PC being read, nothing valid yet
// S_RUN    | fetching; word on imem_instr_ip belongs to fetch_pc_q
// S_HALTED | fetch stopped by halt_ip or a fault; held until rst
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_SIZE = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_ip,
    input  logic        redirect_ip,
    input  logic [31:0] redirect_pc_ip,
    input  logic        halt_ip,
    output logic [31:0] imem_pc_op,
    input  logic [31:0] imem_instr_ip,
    output logic [31:0] instr_op,
    output logic [31:0] instr_pc_op,
    output logic        instr_valid_op,
    output logic        halted_op,
    output logic [1:0]  fault_op,
    output logic [31:0] fetch_count_op
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTED} state_t;

    localparam logic [31:0] PC_MAX      = 32'(IMEM_SIZE - 4);
    localparam logic [1:0]  FAULT_NONE  = 2'b00;
    localparam logic [1:0]  FAULT_ALIGN = 2'b01;
    localparam logic [1:0]  FAULT_RANGE = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [1:0]  fault_q, fault_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            fault_q    <= FAULT_NONE;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        cnt_d      = (valid_q && !stall_ip && !halt_ip) ? cnt_q + 32'd1 : cnt_q;

        case (state_q)
            S_BOOT: begin
                if (halt_ip) begin
                    state_d = S_HALTED;
                    valid_d = 1'b0;
                    fault_d = FAULT_NONE;
                end else if (!stall_ip) begin
                    state_d    = S_RUN;
                    fetch_pc_d = RESET_PC;
                    pc_d       = RESET_PC + 32'd4;
                    valid_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (halt_ip) begin
                    state_d = S_HALTED;
                    valid_d = 1'b0;
                    fault_d = FAULT_NONE;
                end else if (redirect_ip) begin
                    // a legal redirect overrides stall: the old word is squashed upstream
                    if (redirect_pc_ip[1:0] != 2'b00) begin
                        state_d = S_HALTED;
                        valid_d = 1'b0;
                        fault_d = FAULT_ALIGN;
                    end else if (redirect_pc_ip > PC_MAX) begin
                        state_d = S_HALTED;
                        valid_d = 1'b0;
                        fault_d = FAULT_RANGE;
                    end else begin
                        fetch_pc_d = redirect_pc_ip;
                        pc_d       = redirect_pc_ip + 32'd4;
                        valid_d    = 1'b1;
                    end
                end else if (!stall_ip) begin
                    if (pc_q > PC_MAX) begin
                        state_d = S_HALTED;
                        valid_d = 1'b0;
                        fault_d = FAULT_RANGE;
                    end else begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        valid_d    = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_HALTED;
                valid_d = 1'b0;
            end
        endcase
    end

    // stall re-reads fetch_pc_q so the held word is still on the memory output next cycle
    always_comb begin
        imem_pc_op = pc_q;
        case (state_q)
            S_RUN: begin
                if (halt_ip)          imem_pc_op = fetch_pc_q;
                else if (redirect_ip) imem_pc_op = redirect_pc_ip;
                else if (stall_ip)    imem_pc_op = fetch_pc_q;
                else                  imem_pc_op = pc_q;
            end
            S_HALTED: imem_pc_op = fetch_pc_q;
            default:  imem_pc_op = pc_q;
        endcase
        halted_op = (state_q == S_HALTED);
    end

    assign instr_op       = imem_instr_ip;
    assign instr_pc_op    = fetch_pc_q;
    assign instr_valid_op = valid_q;
    assign fault_op       = fault_q;
    assign fetch_count_op = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 512-byte instance for sequencing, stall, redirect, halt and reset,
// and a 16-byte instance for the out-of-range fault.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    logic [31:0] imem_pc, imem_instr, instr, instr_pc, cnt;
    logic        valid, halted;
    logic [1:0]  fault;

    logic [31:0] imem_pc_s, imem_instr_s, instr_s, instr_pc_s, cnt_s;
    logic        valid_s, halted_s;
    logic [1:0]  fault_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_SIZE(512)) u_dut (
        .clk(clk), .rst(rst), .stall_ip(stall), .redirect_ip(redirect),
        .redirect_pc_ip(redirect_pc), .halt_ip(halt), .imem_pc_op(imem_pc),
        .imem_instr_ip(imem_instr), .instr_op(instr), .instr_pc_op(instr_pc),
        .instr_valid_op(valid), .halted_op(halted), .fault_op(fault), .fetch_count_op(cnt)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_SIZE(16)) u_small (
        .clk(clk), .rst(rst), .stall_ip(stall), .redirect_ip(redirect),
        .redirect_pc_ip(redirect_pc), .halt_ip(halt), .imem_pc_op(imem_pc_s),
        .imem_instr_ip(imem_instr_s), .instr_op(instr_s), .instr_pc_op(instr_pc_s),
        .instr_valid_op(valid_s), .halted_op(halted_s), .fault_op(fault_s), .fetch_count_op(cnt_s)
    );

    // synchronous memories: word at byte address a is a ^ tag
    always @(posedge clk) begin
        imem_instr   <= imem_pc ^ 32'hC0DE_0000;
        imem_instr_s <= imem_pc_s ^ 32'h5A5A_0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_valid, input logic [31:0] e_cnt);
        check({tag, ".pc"}, instr_pc, e_pc);
        check({tag, ".instr"}, instr, e_instr);
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".cnt"}, cnt, e_cnt);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".imem_pc"}, imem_pc, 32'h0);
        check({tag, ".pc"}, instr_pc, 32'h0);
        check({tag, ".valid"}, 32'(valid), 32'h0);
        check({tag, ".halted"}, 32'(halted), 32'h0);
        check({tag, ".fault"}, 32'(fault), 32'h0);
        check({tag, ".cnt"}, cnt, 32'h0);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        check("rst.small_cnt", cnt_s, 32'h0);

        // free run from reset
        step(); rst = 1'b0;
        @(negedge clk);
        check("boot.valid", 32'(valid), 32'h0);
        check("boot.imem_pc", imem_pc, 32'h0);
        step(); @(negedge clk);
        check_main("w0", 32'h0, 32'hC0DE_0000, 1'b1, 32'd0);
        step(); @(negedge clk);
        check_main("w1", 32'h4, 32'hC0DE_0004, 1'b1, 32'd1);

        // three stalled cycles holding pc 8
        for (int i = 0; i < 3; i++) begin
            step(); stall = 1'b1;
            @(negedge clk);
            check_main($sformatf("stall%0d", i), 32'h8, 32'hC0DE_0008, 1'b1, 32'd2);
            check($sformatf("stall%0d.imem_pc", i), imem_pc, 32'h8);
        end
        step(); stall = 1'b0;
        @(negedge clk);
        check_main("release", 32'h8, 32'hC0DE_0008, 1'b1, 32'd2);
        check("release.imem_pc", imem_pc, 32'hC);

        // redirect to 0x40 while stalled
        step(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        check_main("w3", 32'hC, 32'hC0DE_000C, 1'b1, 32'd3);
        check("redir.imem_pc", imem_pc, 32'h40);
        step(); stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check_main("tgt", 32'h40, 32'hC0DE_0040, 1'b1, 32'd3);
        check("tgt.imem_pc", imem_pc, 32'h44);

        // misaligned redirect
        step(); redirect = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        check_main("pre_mis", 32'h44, 32'hC0DE_0044, 1'b1, 32'd4);
        check("mis.imem_pc", imem_pc, 32'h42);
        step(); redirect = 1'b0;
        @(negedge clk);
        check("mis.halted", 32'(halted), 32'h1);
        check("mis.fault", 32'(fault), 32'h1);
        check("mis.valid", 32'(valid), 32'h0);
        check("mis.imem_pc", imem_pc, 32'h44);
        check("mis.cnt", cnt, 32'd5);
        for (int i = 0; i < 3; i++) begin
            step(); stall = i[0]; redirect = 1'b1; redirect_pc = 32'h8; halt = (i == 1);
            @(negedge clk);
            check($sformatf("hold%0d.halted", i), 32'(halted), 32'h1);
            check($sformatf("hold%0d.fault", i), 32'(fault), 32'h1);
            check($sformatf("hold%0d.valid", i), 32'(valid), 32'h0);
            check($sformatf("hold%0d.imem_pc", i), imem_pc, 32'h44);
            check($sformatf("hold%0d.cnt", i), cnt, 32'd5);
        end
        stall = 1'b0; redirect = 1'b0; halt = 1'b0;

        // 16-byte memory: run off the end
        do_reset();
        check("s.boot.valid", 32'(valid_s), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            check($sformatf("s.w%0d.pc", i), instr_pc_s, 32'(4 * i));
            check($sformatf("s.w%0d.instr", i), instr_s, 32'h5A5A_0000 | 32'(4 * i));
            check($sformatf("s.w%0d.valid", i), 32'(valid_s), 32'h1);
        end
        check("s.end.imem_pc", imem_pc_s, 32'h10);
        step(); @(negedge clk);
        check("s.oor.halted", 32'(halted_s), 32'h1);
        check("s.oor.fault", 32'(fault_s), 32'h2);
        check("s.oor.valid", 32'(valid_s), 32'h0);
        check("s.oor.pc", instr_pc_s, 32'hC);
        check("s.oor.cnt", cnt_s, 32'd4);

        do_reset();
        step(); redirect = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        check("s.r0.valid", 32'(valid_s), 32'h1);
        step(); redirect = 1'b0;
        @(negedge clk);
        check("s.redir.halted", 32'(halted_s), 32'h1);
        check("s.redir.fault", 32'(fault_s), 32'h2);
        check("s.redir.valid", 32'(valid_s), 32'h0);

        // asynchronous reset mid-run at pc 0x20 with stall and redirect active
        do_reset();
        step(); redirect = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        check_main("r0", 32'h0, 32'hC0DE_0000, 1'b1, 32'd0);
        step(); redirect = 1'b0;
        @(negedge clk);
        check_main("r20", 32'h20, 32'hC0DE_0020, 1'b1, 32'd1);
        step(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; rst = 1'b1;
        #1;
        check_reset("async");
        step(); @(negedge clk);
        check_reset("async_hold");

        // halt and misaligned redirect in the same cycle: halt wins
        step(); rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check("b.boot.valid", 32'(valid), 32'h0);
        step(); halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        check("hr.valid", 32'(valid), 32'h1);
        check("hr.imem_pc", imem_pc, 32'h0);
        step(); halt = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check("hr.halted", 32'(halted), 32'h1);
        check("hr.fault", 32'(fault), 32'h0);
        check("hr.valid2", 32'(valid), 32'h0);
        check("hr.cnt", cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
